alu_input_seq: RTL

Operand-entry sequencer that drives the 4-bit combinational ALU from board switches and a single push button. It synchronises and debounces the button, walks a user through entering A, B and the opcode, presents them to the ALU, and latches the returned result with a valid flag for the display path. It sits between board I/O and the ALU inputs, acting as the initiator whose outputs are the ALU's `A`, `B` and `op` operands.

---
 rtl/alu_input_seq_if.sv | 24 ++
 rtl/alu_input_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_input_seq_if.sv
// Operand bus between the entry sequencer and the 4-bit combinational ALU.
// The sequencer drives the operands; the ALU returns its combinational result.
interface alu_input_seq_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_res;

    modport master (
        output alu_a,
        output alu_b,
        output alu_op,
        input  alu_res
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_op,
        output alu_res
    );
endinterface

// File: rtl/alu_input_seq.sv
// Push-button operand-entry sequencer: debounces the enter button, captures A, B
// and the opcode from the switches, then latches the ALU result for display.
module alu_input_seq #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      sw,
    input  logic            btn,
    input  logic            clr,
    alu_input_seq_if.master alu,
    output logic [3:0]      res,
    output logic            res_valid,
    output logic [2:0]      phase
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1;
    logic       s2;
    logic       stable;
    logic       stable_d;
    logic [7:0] cnt;
    logic       enter;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] a_q;
    logic [3:0] a_nxt;
    logic [3:0] b_q;
    logic [3:0] b_nxt;
    logic [2:0] op_q;
    logic [2:0] op_nxt;
    logic [3:0] res_q;
    logic [3:0] res_nxt;
    logic       vld_q;
    logic       vld_nxt;

    // Button synchroniser and debounce; clr deliberately leaves this path alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_d <= stable;
            if (s2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

    // Rising edge of the accepted level only, so a release never advances the FSM.
    assign enter = stable & ~stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_A;
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            op_q  <= 3'd0;
            res_q <= 4'd0;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            op_q  <= op_nxt;
            res_q <= res_nxt;
            vld_q <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        res_nxt   = res_q;
        vld_nxt   = vld_q;

        if (clr) begin
            state_nxt = S_A;
            a_nxt     = 4'd0;
            b_nxt     = 4'd0;
            op_nxt    = 3'd0;
            res_nxt   = 4'd0;
            vld_nxt   = 1'b0;
        end else begin
            unique case (state)
                S_A: begin
                    vld_nxt = 1'b0;
                    if (enter) begin
                        a_nxt     = sw;
                        state_nxt = S_B;
                    end
                end
                S_B: begin
                    vld_nxt = 1'b0;
                    if (enter) begin
                        b_nxt     = sw;
                        state_nxt = S_OP;
                    end
                end
                S_OP: begin
                    vld_nxt = 1'b0;
                    if (enter) begin
                        op_nxt    = sw[2:0];
                        state_nxt = S_EXEC;
                    end
                end
                // Operands have been stable for a full cycle, so the ALU output has settled.
                S_EXEC: begin
                    res_nxt   = alu.alu_res;
                    vld_nxt   = 1'b1;
                    state_nxt = S_SHOW;
                end
                S_SHOW: begin
                    if (enter) begin
                        vld_nxt   = 1'b0;
                        state_nxt = S_A;
                    end
                end
                default: begin
                    state_nxt = S_A;
                    a_nxt     = 4'd0;
                    b_nxt     = 4'd0;
                    op_nxt    = 3'd0;
                    res_nxt   = 4'd0;
                    vld_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign alu.alu_a  = a_q;
    assign alu.alu_b  = b_q;
    assign alu.alu_op = op_q;
    assign res        = res_q;
    assign res_valid  = vld_q;
    assign phase      = state;

endmodule
